// File: rtl/branch_predict_ctrl_pkg.sv
// Shared definitions for the branch predictor: branch-type encodings, 2-bit
// counter states, controller FSM states and table write operations.
package branch_predict_ctrl_pkg;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BGE      = 3'd4,
    BLTU     = 3'd5,
    BGEU     = 3'd6
  } branch_type_t;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    WR_NONE      = 2'd0,
    WR_INIT      = 2'd1,
    WR_TAKEN     = 2'd2,
    WR_NOT_TAKEN = 2'd3
  } wr_op_t;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_bht_btb_table.sv
// Combined BHT/BTB storage: one asynchronous read port, one synchronous
// read-modify-write port. Only built when BRANCH_PREDICT_EN is defined.
`ifdef BRANCH_PREDICT_EN
module bht_btb_table
  import branch_predict_ctrl_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_target,
  input  wr_op_t           wr_op,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target
);
  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       cnt_mem    [DEPTH];
  logic             valid_mem  [DEPTH];
  logic [TAG_W-1:0] tag_mem    [DEPTH];
  logic [31:0]      target_mem [DEPTH];

  assign rd_cnt    = cnt_mem[rd_idx];
  assign rd_valid  = valid_mem[rd_idx];
  assign rd_tag    = tag_mem[rd_idx];
  assign rd_target = target_mem[rd_idx];

  // Not-taken training only moves the counter; tag/target stay as learned.
  always_ff @(posedge clk) begin
    case (wr_op)
      WR_INIT: begin
        cnt_mem[wr_idx]   <= CNT_WNT;
        valid_mem[wr_idx] <= 1'b0;
      end
      WR_TAKEN: begin
        cnt_mem[wr_idx]    <= sat_update(cnt_mem[wr_idx], 1'b1);
        valid_mem[wr_idx]  <= 1'b1;
        tag_mem[wr_idx]    <= wr_tag;
        target_mem[wr_idx] <= wr_target;
      end
      WR_NOT_TAKEN: cnt_mem[wr_idx] <= sat_update(cnt_mem[wr_idx], 1'b0);
      default: ;
    endcase
  end

endmodule
`endif

// File: rtl/branch_predict_ctrl.sv
// Branch prediction / redirect controller. Define BRANCH_PREDICT_EN for the
// BHT/BTB predictor; otherwise static predict-not-taken with perf counters.
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        StallE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] PCE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        RedirectE,
  output logic [31:0] RedirectPCE,
  output logic        InitBusy,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);
  logic        is_branch;
  logic        mispredict;
  logic [31:0] branch_cnt_reg;
  logic [31:0] mispred_cnt_reg;

  assign is_branch = (branch_type_t'(BranchTypeE) != NOBRANCH);

`ifdef BRANCH_PREDICT_EN
  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  wr_op_t           wr_op;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       rd_cnt;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_target;
  logic             run;

  bht_btb_table #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_table (
    .clk       (clk),
    .rd_idx    (PCF[IDX_W+1:2]),
    .rd_cnt    (rd_cnt),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .wr_op     (wr_op),
    .wr_idx    (wr_idx),
    .wr_tag    (PCE[IDX_W+TAG_W+1:IDX_W+2]),
    .wr_target (BrTargetE)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_INIT;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // The write port is shared: the clearing sweep owns it in INIT, training in RUN.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    wr_op      = WR_NONE;
    wr_idx     = PCE[IDX_W+1:2];
    case (state_reg)
      ST_INIT: begin
        wr_op    = WR_INIT;
        wr_idx   = ptr_reg;
        ptr_next = ptr_reg + IDX_W'(1);
        if (&ptr_reg) state_next = ST_RUN;
      end
      default: begin
        if (is_branch && !StallE) wr_op = BranchE ? WR_TAKEN : WR_NOT_TAKEN;
      end
    endcase
  end

  assign run         = rst_n && (state_reg == ST_RUN);
  assign PredTakenF  = run && rd_cnt[1] && rd_valid && (rd_tag == PCF[IDX_W+TAG_W+1:IDX_W+2]);
  assign PredTargetF = PredTakenF ? rd_target : PCF + 32'd4;
  assign InitBusy    = !run;
  assign mispredict  = is_branch &&
                       ((BranchE != PredTakenE) || (BranchE && (PredTargetE != BrTargetE)));
`else
  logic unused_pred;
  assign unused_pred = ^{PredTakenE, PredTargetE};
  assign PredTakenF  = 1'b0;
  assign PredTargetF = PCF + 32'd4;
  assign InitBusy    = 1'b0;
  assign mispredict  = is_branch && BranchE;
`endif

  assign RedirectE   = rst_n && mispredict;
  assign FlushD      = RedirectE;
  assign FlushE      = RedirectE;
  assign RedirectPCE = RedirectE ? (BranchE ? BrTargetE : PCE + 32'd4) : 32'd0;

  // Counters run in every state; only a stalled EX stage holds them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt_reg  <= '0;
      mispred_cnt_reg <= '0;
    end else if (is_branch && !StallE) begin
      branch_cnt_reg <= branch_cnt_reg + 32'd1;
      if (mispredict) mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
    end
  end

  assign BranchCnt  = branch_cnt_reg;
  assign MispredCnt = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: per-cycle model comparison plus
// directed literal expectations; handles both BRANCH_PREDICT_EN builds.
module tb_branch_predict_ctrl;
  import branch_predict_ctrl_pkg::*;

  localparam int IDX_W = 6;
  localparam int TAG_W = 8;
  localparam int DEPTH = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        StallE;
  logic [2:0]  BranchTypeE;
  logic        BranchE;
  logic [31:0] PCE;
  logic [31:0] BrTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        FlushD, FlushE, RedirectE;
  logic [31:0] RedirectPCE;
  logic        InitBusy;
  logic [31:0] BranchCnt, MispredCnt;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  branch_predict_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .StallE(StallE), .BranchTypeE(BranchTypeE), .BranchE(BranchE), .PCE(PCE),
    .BrTargetE(BrTargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .FlushD(FlushD), .FlushE(FlushE), .RedirectE(RedirectE), .RedirectPCE(RedirectPCE),
    .InitBusy(InitBusy), .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: table contents as plain arrays, INIT as a countdown.
  int          m_init_left = DEPTH;
  int          m_cnt   [DEPTH];
  bit          m_valid [DEPTH];
  int unsigned m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  logic [31:0] m_bcnt = 0;
  logic [31:0] m_mcnt = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc >> (IDX_W + 2)) % (1 << TAG_W);
  endfunction

  function automatic bit m_branch();
    return BranchTypeE != 3'd0;
  endfunction

  function automatic bit m_mispred();
    if (!m_branch()) return 0;
`ifdef BRANCH_PREDICT_EN
    if (BranchE != PredTakenE) return 1;
    return BranchE && (PredTargetE != BrTargetE);
`else
    return BranchE;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init_left = DEPTH;
      m_bcnt = 0;
      m_mcnt = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_cnt[i] = 1;
        m_valid[i] = 0;
      end
    end else begin
      if (m_branch() && !StallE) begin
        m_bcnt = m_bcnt + 1;
        if (m_mispred()) m_mcnt = m_mcnt + 1;
        if (m_init_left == 0) begin
          if (BranchE) begin
            m_cnt[idx_of(PCE)]   = (m_cnt[idx_of(PCE)] >= 3) ? 3 : m_cnt[idx_of(PCE)] + 1;
            m_valid[idx_of(PCE)] = 1;
            m_tag[idx_of(PCE)]   = tag_of(PCE);
            m_tgt[idx_of(PCE)]   = BrTargetE;
          end else begin
            m_cnt[idx_of(PCE)] = (m_cnt[idx_of(PCE)] <= 0) ? 0 : m_cnt[idx_of(PCE)] - 1;
          end
        end
      end
      if (m_init_left > 0) m_init_left--;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit          exp_taken, exp_busy, exp_redir;
      logic [31:0] exp_tgt;
`ifdef BRANCH_PREDICT_EN
      exp_taken = rst_n && (m_init_left == 0) && (m_cnt[idx_of(PCF)] >= 2) &&
                  m_valid[idx_of(PCF)] && (m_tag[idx_of(PCF)] == tag_of(PCF));
      exp_busy  = !rst_n || (m_init_left > 0);
`else
      exp_taken = 0;
      exp_busy  = 0;
`endif
      exp_tgt   = exp_taken ? m_tgt[idx_of(PCF)] : PCF + 32'd4;
      exp_redir = rst_n && m_mispred();
      check("cyc_PredTakenF", PredTakenF, exp_taken);
      check("cyc_PredTargetF", PredTargetF, exp_tgt);
      check("cyc_InitBusy", InitBusy, exp_busy);
      check("cyc_RedirectE", RedirectE, exp_redir);
      check("cyc_FlushD", FlushD, exp_redir);
      check("cyc_FlushE", FlushE, exp_redir);
      if (!rst_n) check("cyc_RedirectPCE_rst", RedirectPCE, 32'd0);
      else if (exp_redir) check("cyc_RedirectPCE", RedirectPCE, BranchE ? BrTargetE : PCE + 32'd4);
      check("cyc_BranchCnt", BranchCnt, m_bcnt);
      check("cyc_MispredCnt", MispredCnt, m_mcnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic br(input logic [2:0] t, input logic taken, input logic [31:0] pce,
                    input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt,
                    input logic stall);
    BranchTypeE = t; BranchE = taken; PCE = pce; BrTargetE = tgt;
    PredTakenE = ptaken; PredTargetE = ptgt; StallE = stall;
  endtask

  task automatic idle();
    br(NOBRANCH, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic count_init(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      at_neg();
      if (InitBusy) n++;
      else break;
    end
  endtask

`ifdef BRANCH_PREDICT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  initial begin
    int n;
    rst_n = 1'b0;
    PCF = 32'h0;
    idle();
    @(posedge clk);
    started = 1;
    @(posedge clk);
    #2;
    // 1: reset values, with a mispredicting branch presented during reset
    br(BEQ, 1'b1, 32'h100, 32'h200, 1'b0, 32'h0, 1'b0);
    at_neg();
    check("rst_RedirectE", RedirectE, 32'd0);
    check("rst_RedirectPCE", RedirectPCE, 32'd0);
    check("rst_InitBusy", InitBusy, EN ? 32'd1 : 32'd0);
    check("rst_PredTargetF", PredTargetF, 32'h4);
    cyc();
    rst_n = 1'b1;
    idle();
    count_init(n);
    check("sweep_len", n, EN ? 32'd64 : 32'd0);

    // 2: cold taken branch
    cyc();
    br(BEQ, 1'b1, 32'h100, 32'h200, 1'b0, 32'h0, 1'b0);
    PCF = 32'h100;
    at_neg();
    check("cold_RedirectE", RedirectE, 32'd1);
    check("cold_FlushD", FlushD, 32'd1);
    check("cold_RedirectPCE", RedirectPCE, 32'h200);
    check("cold_same_cycle_pred", PredTakenF, 32'd0);
    cyc();
    idle();
    at_neg();
    check("cold_next_pred", PredTakenF, EN ? 32'd1 : 32'd0);
    check("cold_next_target", PredTargetF, EN ? 32'h200 : 32'h104);

    // 3: saturation 11 -> 10 still taken, then 01 not taken; alias tag miss
    for (int i = 0; i < 4; i++) begin
      cyc();
      br(BEQ, 1'b1, 32'h100, 32'h200, 1'b1, 32'h200, 1'b0);
    end
    cyc();
    br(BEQ, 1'b0, 32'h100, 32'h200, 1'b1, 32'h200, 1'b0);
    cyc();
    idle();
    at_neg();
    check("sat_one_nt", PredTakenF, EN ? 32'd1 : 32'd0);
    cyc();
    PCF = 32'h200;
    at_neg();
    check("alias_tag_miss", PredTakenF, 32'd0);
    check("alias_target", PredTargetF, 32'h204);
    cyc();
    PCF = 32'h100;
    br(BEQ, 1'b0, 32'h100, 32'h200, 1'b1, 32'h200, 1'b0);
    cyc();
    idle();
    at_neg();
    check("sat_two_nt", PredTakenF, 32'd0);

    // 4: not-taken mispredict
    cyc();
    br(BNE, 1'b0, 32'h300, 32'h380, 1'b1, 32'h380, 1'b0);
    at_neg();
    check("nt_RedirectE", RedirectE, EN ? 32'd1 : 32'd0);
    if (EN) check("nt_RedirectPCE", RedirectPCE, 32'h304);
    cyc();
    idle();
    at_neg();
    check("nt_BranchCnt", BranchCnt, 32'd8);
    check("nt_MispredCnt", MispredCnt, EN ? 32'd4 : 32'd5);

    // wrong-target mispredict, then a non-branch with BranchE high
    cyc();
    br(BLT, 1'b1, 32'h140, 32'h500, 1'b1, 32'h600, 1'b0);
    at_neg();
    check("tgt_RedirectPCE", RedirectPCE, 32'h500);
    cyc();
    br(NOBRANCH, 1'b1, 32'h180, 32'h999, 1'b0, 32'h0, 1'b0);
    at_neg();
    check("nobr_RedirectE", RedirectE, 32'd0);
    cyc();
    idle();
    PCF = 32'h140;
    at_neg();
    check("btb_target", PredTargetF, EN ? 32'h500 : 32'h144);

    // 5: stalled mispredict redirects but does not train or count
    cyc();
    PCF = 32'h100;
    br(BEQ, 1'b1, 32'h100, 32'h200, 1'b0, 32'h0, 1'b1);
    at_neg();
    check("stall_RedirectE", RedirectE, 32'd1);
    check("stall_RedirectPCE", RedirectPCE, 32'h200);
    cyc();
    idle();
    at_neg();
    check("stall_BranchCnt", BranchCnt, 32'd9);
    check("stall_MispredCnt", MispredCnt, EN ? 32'd5 : 32'd6);
    check("stall_no_train", PredTakenF, 32'd0);

    // 6: reset in the middle of a sweep, with branches counted during INIT
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    br(BEQ, 1'b1, 32'h140, 32'h700, 1'b0, 32'h0, 1'b0);
    repeat (30) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    idle();
    PCF = 32'h140;
    count_init(n);
    check("resweep_len", n, EN ? 32'd64 : 32'd0);
    check("resweep_BranchCnt", BranchCnt, 32'd0);
    check("resweep_MispredCnt", MispredCnt, 32'd0);
    check("resweep_cleared", PredTakenF, 32'd0);

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Branch prediction and redirect controller for the 5-stage RISC-V pipeline. In IF it predicts taken/not-taken and the target for the fetch PC using a 2-bit-counter BHT and a direct-mapped BTB. In EX it compares the prediction with the resolved branch outcome, raises flush and redirect on a mispredict, and trains the tables. It also keeps branch and mispredict performance counters.

## Interface
- `IDX_W`, default 6: table index width; 2^IDX_W entries.
- `TAG_W`, default 8: BTB tag width.
- `clk` in 1: core clock.
- `rst_n` in 1: synchronous, active-low reset.
- `PCF` in 32: fetch PC.
- `PredTakenF` out 1: predict taken for `PCF`.
- `PredTargetF` out 32: predicted target for `PCF`.
- `StallE` in 1: EX stage held; suppresses training and counting.
- `BranchTypeE` in 3: resolved branch type (shared encodings; `NOBRANCH` = not a branch).
- `BranchE` in 1: resolved taken, from branch decision logic.
- `PCE` in 32: PC of the EX instruction.
- `BrTargetE` in 32: computed branch target.
- `PredTakenE` in 1: prediction piped from IF for this instruction.
- `PredTargetE` in 32: predicted target piped from IF for this instruction.
- `FlushD`, `FlushE` out 1: squash the ID and EX-bound instructions.
- `RedirectE` out 1: fetch must load `RedirectPCE`.
- `RedirectPCE` out 32: corrected fetch PC.
- `InitBusy` out 1: table clear in progress.
- `BranchCnt`, `MispredCnt` out 32: performance counters.

## Operation
- Index = `PC[IDX_W+1:2]`; tag = `PC[IDX_W+TAG_W+1:IDX_W+2]`.
- Each entry holds: a 2-bit counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T), a valid bit, a tag, and a 32-bit target.
- FSM states:
  - INIT: a sweep pointer writes every entry with counter=01 and valid=0, one entry per cycle. Move to RUN after entry 2^IDX_W−1.
  - RUN: normal operation.
- Any cycle with `rst_n`=0 forces INIT with the pointer at 0, including reset in the middle of a sweep.
- Prediction (RUN only):
  - `PredTakenF` = counter[1] AND valid AND tag match.
  - `PredTargetF` = stored target when `PredTakenF`=1, else `PCF+4`.
  - In INIT: `PredTakenF`=0 and `PredTargetF`=`PCF+4`.
- Branch resolution: an instruction is a branch when `BranchTypeE`≠`NOBRANCH`.
- Mispredict = branch AND (`BranchE`≠`PredTakenE` OR (`BranchE` AND `PredTargetE`≠`BrTargetE`)).
- On mispredict:
  - `RedirectE`=`FlushD`=`FlushE`=1.
  - `RedirectPCE` = `BranchE` ? `BrTargetE` : `PCE+4`.
  - Redirect is signalled even during INIT.
- Training (RUN, branch, `StallE`=0):
  - Counter saturates up on taken, down on not-taken.
  - When taken, also write valid=1, tag and `BrTargetE`.
  - Training is ignored during INIT.
- Same-cycle read and write of one index: the read returns the old contents; no bypass.
- Counters (branch, `StallE`=0, any state):
  - `BranchCnt`+1 per branch; `MispredCnt`+1 per mispredict.
  - Both wrap modulo 2^32.

## Timing
- Prediction outputs are combinational from `PCF` and the table state, available the same cycle.
- Mispredict outputs are combinational from EX inputs, available the same cycle.
- Table and counter updates are visible on the next rising edge.
- INIT lasts exactly 2^IDX_W cycles after `rst_n` deasserts (64 by default). `InitBusy`=1 throughout and 0 from the first RUN cycle.
- Reset values:
  - `PredTakenF`=0, `PredTargetF`=`PCF+4`.
  - `FlushD`=`FlushE`=`RedirectE`=0, `RedirectPCE`=0.
  - `InitBusy`=1, `BranchCnt`=`MispredCnt`=0.
  - Flush/redirect outputs are held 0 while `rst_n`=0.

## Configuration
- `BRANCH_PREDICT_EN` defined: full behaviour as above.
- Not defined:
  - Tables and FSM are removed; static predict-not-taken.
  - `PredTakenF`=0, `PredTargetF`=`PCF+4`, `InitBusy`=0.
  - Mispredict = branch AND `BranchE`.
  - Performance counters are retained.

## Structure
- Shared package holds: branch-type encodings (`BEQ`…`BGEU`, `NOBRANCH`, shared with branch decision logic), the counter state constants, and the INIT/RUN state encoding.
- One sub-module, `bht_btb_table`: the storage array with one asynchronous read port and one synchronous write port. The controller drives the write port from either the INIT sweep or training.

## Test plan
1. **Reset and sweep.** Hold `rst_n`=0 for 3 cycles, then release. Expect `InitBusy`=1 for 64 cycles, then 0; `PredTakenF`=0 throughout.
2. **Cold taken branch.** `PCE`=0x100, `BEQ`, `BranchE`=1, `PredTakenE`=0, `BrTargetE`=0x200. Expect `RedirectE`/`FlushD`/`FlushE`=1 and `RedirectPCE`=0x200. On the next cycle, `PCF`=0x100 gives `PredTakenF`=1 and `PredTargetF`=0x200.
3. **Saturation.** Train the same PC taken 4 times, then not-taken once. Expect the prediction still taken (11→10). After a second not-taken, expect `PredTakenF`=0.
4. **Not-taken mispredict.** `PredTakenE`=1, `BranchE`=0, `PCE`=0x300. Expect `RedirectPCE`=0x304 and `MispredCnt`+1.
5. **Stall.** Mispredicting branch with `StallE`=1. Expect redirect asserted but counters and table unchanged.
6. **Reset mid-sweep.** Assert `rst_n`=0 at sweep cycle 30. Expect the full 64-cycle INIT to restart from entry 0 and both counters to read 0.
